uart_tx_buf: RTL

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_tx_buf.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: a DEPTH-entry byte FIFO feeding a
// shift-register serializer with a per-frame latched bit period.
module uart_tx_buf #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trmt,
    input  logic [7:0]  tx_data,
    input  logic [12:0] baud_div,
    input  logic        clr_ovf,
    output logic        TX,
    output logic        full,
    output logic        empty,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        ovf
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned BAUD_W  = 13;
    localparam int unsigned FRAME_W = 10;
    localparam int unsigned BIT_W   = 4;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XMIT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;

    logic [FRAME_W-1:0] shreg;
    logic [BAUD_W-1:0]  baud_q;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [BIT_W-1:0]   bit_cnt;

    logic push_c;
    logic drop_c;
    logic pop_c;
    logic load_c;
    logic bit_end_c;
    logic frame_end_c;

    // FIFO write acceptance and bit timing strobes
    always_comb begin
        push_c      = trmt && !full;
        drop_c      = trmt && full;
        bit_end_c   = (state == XMIT) && (baud_cnt == baud_q);
        frame_end_c = bit_end_c && (bit_cnt == LAST_BIT);
        count_next  = count + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; a load pops the FIFO head into the shifter
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    load_c     = 1'b1;
                    state_next = XMIT;
                end
            end
            XMIT: begin
                if (frame_end_c) begin
                    if (!empty) begin
                        load_c = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        pop_c = load_c;
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers, occupancy flags and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
            if (drop_c) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // Serializer: TX follows the shifter LSB one cycle later, idling high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg    <= '1;
            baud_q   <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            TX       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            TX      <= (state == XMIT) ? shreg[0] : 1'b1;
            tx_busy <= (state_next == XMIT);
            tx_done <= frame_end_c;
            if (load_c) begin
                shreg    <= {1'b1, mem[rd_ptr], 1'b0};
                baud_q   <= baud_div;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (bit_end_c) begin
                shreg    <= {1'b1, shreg[FRAME_W-1:1]};
                baud_cnt <= '0;
                bit_cnt  <= bit_cnt + BIT_W'(1);
            end else if (state == XMIT) begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end
        end
    end

endmodule
